// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: multi-cycle controller between a command source and an
// external 16-bit combinational ALU. It owns an NREG x 16 register file and
// the {C,N,Z} flags.
//
// Flow: IDLE -> FETCH -> EXEC -> RESP -> IDLE.
// EXEC lasts two cycles:
//   - Cycle 1 loads the registered ALU inputs.
//   - Cycle 2 captures the ALU result after it has had a full cycle to settle.
//
// Timing: with the command accepted at edge k, rsp_valid rises after edge k+3.
//
// Handshakes (valid/ready):
//   - A transfer happens on a rising edge where valid && ready.
//   - The producer holds valid and its payload until that edge.
//   - ready is a pure function of the FSM state and never depends on valid.
//
// Optional build macro:
//   PERF_CNT_EN adds the perf_cmds and perf_stall counters.
module alu_cmd_sequencer #(
  parameter int NREG = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [2:0]                cmd_op,
  input  logic [$clog2(NREG)-1:0]   cmd_dst,
  input  logic [$clog2(NREG)-1:0]   cmd_srca,
  input  logic [$clog2(NREG)-1:0]   cmd_srcb,
  input  logic [15:0]               cmd_imm,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [15:0]               rsp_data,
  output logic [2:0]                rsp_flags,
  output logic [15:0]               alu_inA,
  output logic [15:0]               alu_inB,
  output logic                      alu_inC,
  output logic [2:0]                alu_opc,
  input  logic [15:0]               alu_out,
  input  logic                      alu_zer,
  input  logic                      alu_neg
`ifdef PERF_CNT_EN
  ,
  output logic [15:0]               perf_cmds,
  output logic [15:0]               perf_stall
`endif
);

  localparam int AW = $clog2(NREG);
  localparam logic [2:0] OP_ADDC = 3'b010;
  localparam logic [2:0] OP_LOAD = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_RESP} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [15:0]     regs [NREG];
  logic [2:0]      op_q;
  logic [AW-1:0]   dst_q;
  logic [AW-1:0]   srca_q;
  logic [AW-1:0]   srcb_q;
  logic [15:0]     imm_q;
  logic [15:0]     op_a;
  logic [15:0]     op_b;
  logic            alu_armed;   // ALU inputs are loaded; the next EXEC edge captures
  logic            flag_c;
  logic            flag_n;
  logic            flag_z;
  logic            cmd_fire;
  logic            rsp_fire;
  logic            capture;
  logic [15:0]     result;
  logic            add_carry;

  assign cmd_fire  = cmd_valid && (state == S_IDLE);
  assign rsp_fire  = rsp_ready && (state == S_RESP);
  assign capture   = (state == S_EXEC) && alu_armed;
  assign result    = (op_q == OP_LOAD) ? imm_q : alu_out;
  assign add_carry = ({1'b0, op_a} + {1'b0, op_b} + {16'b0, flag_c}) > 17'h0FFFF;
  assign rsp_flags = {flag_c, flag_n, flag_z};

  // State register; reset aborts any command in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = S_FETCH;
      end
      S_FETCH: state_nxt = S_EXEC;
      S_EXEC:  if (alu_armed) state_nxt = S_RESP;
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Command latch, operand fetch, ALU drive and result/flag capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= '0;
      dst_q     <= '0;
      srca_q    <= '0;
      srcb_q    <= '0;
      imm_q     <= '0;
      op_a      <= '0;
      op_b      <= '0;
      alu_armed <= 1'b0;
      alu_inA   <= '0;
      alu_inB   <= '0;
      alu_inC   <= 1'b0;
      alu_opc   <= '0;
      rsp_data  <= '0;
      flag_c    <= 1'b0;
      flag_n    <= 1'b0;
      flag_z    <= 1'b0;
    end else begin
      if (cmd_fire) begin
        op_q   <= cmd_op;
        dst_q  <= cmd_dst;
        srca_q <= cmd_srca;
        srcb_q <= cmd_srcb;
        imm_q  <= cmd_imm;
      end
      if (state == S_FETCH) begin
        op_a      <= regs[srca_q];
        op_b      <= regs[srcb_q];
        alu_armed <= 1'b0;
      end
      if ((state == S_EXEC) && !alu_armed) begin
        alu_armed <= 1'b1;
        // LOAD bypasses the ALU, so opcode 111 is never presented to it.
        if (op_q != OP_LOAD) begin
          alu_inA <= op_a;
          alu_inB <= op_b;
          alu_opc <= op_q;
          alu_inC <= (op_q == OP_ADDC) ? flag_c : 1'b0;
        end
      end
      if (capture) begin
        rsp_data <= result;
        if (op_q == OP_LOAD) begin
          flag_z <= (imm_q == 16'h0000);
          flag_n <= imm_q[15];
        end else begin
          flag_z <= alu_zer;
          flag_n <= alu_neg;
          if (op_q == OP_ADDC) flag_c <= add_carry;
        end
      end
    end
  end

  // Register file; written on the edge that enters RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (capture) begin
      regs[dst_q] <= result;
    end
  end

`ifdef PERF_CNT_EN
  // Completed-command and response-stall counters; both wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cmds  <= '0;
      perf_stall <= '0;
    end else begin
      if (rsp_fire) perf_cmds <= perf_cmds + 16'd1;
      if ((state == S_RESP) && !rsp_ready) perf_stall <= perf_stall + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Testbench for alu_cmd_sequencer.
// Contents:
//   - A behavioural ALU attached to the ALU ports.
//   - A directed vector table.
//   - Stall and reset-in-EXEC sequences.
//   - Randomized commands checked against an arithmetic reference model.
// The perf counters are checked only when PERF_CNT_EN is defined.
module tb_alu_cmd_sequencer;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [2:0]  cmd_dst;
  logic [2:0]  cmd_srca;
  logic [2:0]  cmd_srcb;
  logic [15:0] cmd_imm;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic [2:0]  rsp_flags;
  logic [15:0] alu_inA;
  logic [15:0] alu_inB;
  logic        alu_inC;
  logic [2:0]  alu_opc;
  logic [15:0] alu_out;
  logic        alu_zer;
  logic        alu_neg;
`ifdef PERF_CNT_EN
  logic [15:0] perf_cmds;
  logic [15:0] perf_stall;
  int          exp_cmds;
  int          exp_stall;
`endif

  int total;
  int bad;

  // Reference model state: register file and carry flag.
  int regs_m [8];
  int c_m;

  alu_cmd_sequencer #(.NREG(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_dst(cmd_dst), .cmd_srca(cmd_srca), .cmd_srcb(cmd_srcb), .cmd_imm(cmd_imm),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_flags(rsp_flags),
    .alu_inA(alu_inA), .alu_inB(alu_inB), .alu_inC(alu_inC), .alu_opc(alu_opc),
    .alu_out(alu_out), .alu_zer(alu_zer), .alu_neg(alu_neg)
`ifdef PERF_CNT_EN
    , .perf_cmds(perf_cmds), .perf_stall(perf_stall)
`endif
  );

  // Clock generation.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural ALU.
  logic signed [15:0] b_half;
  always_comb begin
    b_half = $signed(alu_inB) >>> 1;
    case (alu_opc)
      3'b000:  alu_out = 16'h0000 - alu_inA;
      3'b001:  alu_out = alu_inA + 16'h0001;
      3'b010:  alu_out = alu_inA + alu_inB + {15'b0, alu_inC};
      3'b011:  alu_out = alu_inA + b_half;
      3'b100:  alu_out = alu_inA & alu_inB;
      3'b101:  alu_out = alu_inA | alu_inB;
      3'b110:  alu_out = {alu_inA[7:0], alu_inB[7:0]};
      default: alu_out = 16'hDEAD;
    endcase
    alu_zer = (alu_out == 16'h0000);
    alu_neg = alu_out[15];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) regs_m[i] = 0;
    c_m = 0;
  endtask

  // Architectural effect of one command, in plain integer arithmetic.
  task automatic model_step(input logic [2:0] op, input int dst, input int srca, input int srcb,
                            input logic [15:0] imm, output logic [15:0] d,
                            output logic [2:0] f, output logic inc);
    int a, b, r, sb, half;
    a   = regs_m[srca];
    b   = regs_m[srcb];
    inc = (op == 3'b010) ? c_m[0] : 1'b0;
    r   = 0;
    case (op)
      3'd0: r = 65536 - a;
      3'd1: r = a + 1;
      3'd2: begin
        r   = a + b + c_m;
        c_m = (r > 65535) ? 1 : 0;
      end
      3'd3: begin
        sb   = (b >= 32768) ? b - 65536 : b;
        half = (sb >= 0) ? sb / 2 : -((1 - sb) / 2);
        r    = a + half;
      end
      3'd4: r = a & b;
      3'd5: r = a | b;
      3'd6: r = (a % 256) * 256 + (b % 256);
      default: r = int'(imm);
    endcase
    r = r & 32'h0000FFFF;
    regs_m[dst] = r;
    d = r[15:0];
    f = {c_m[0], (r >= 32768), (r == 0)};
  endtask

  // Issue one command at a negedge in IDLE and check the response.
  // The response is held for `stall` RESP cycles; returns at a negedge in IDLE.
  task automatic do_cmd(input logic [2:0] op, input logic [2:0] dst, input logic [2:0] srca,
                        input logic [2:0] srcb, input logic [15:0] imm, input int stall,
                        input logic [15:0] exp_d, input logic [2:0] exp_f, input logic exp_inc);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_dst   = dst;
    cmd_srca  = srca;
    cmd_srcb  = srcb;
    cmd_imm   = imm;
    rsp_ready = 1'b0;
    check("cmd_ready_idle", {31'b0, cmd_ready}, 32'd1);
    @(negedge clk);                     // after accept edge k: FETCH
    cmd_valid = 1'b0;
    check("no_ready_fetch", {31'b0, cmd_ready}, 32'd0);
    @(negedge clk);                     // after k+1
    @(negedge clk);                     // after k+2
    check("rsp_valid_early", {31'b0, rsp_valid}, 32'd0);
    @(negedge clk);                     // after k+3: RESP
    check("rsp_valid_k3", {31'b0, rsp_valid}, 32'd1);
    check("rsp_data", {16'b0, rsp_data}, {16'b0, exp_d});
    check("rsp_flags", {29'b0, rsp_flags}, {29'b0, exp_f});
    check("cmd_ready_resp", {31'b0, cmd_ready}, 32'd0);
    if (op != 3'b111) check("alu_opc", {29'b0, alu_opc}, {29'b0, op});
    if (op == 3'b010) check("alu_inC", {31'b0, alu_inC}, {31'b0, exp_inc});
    for (int i = 0; i < stall; i++) begin
      cmd_valid = 1'b1;
      cmd_op    = 3'($urandom_range(0, 7));
      cmd_dst   = 3'($urandom_range(0, 7));
      cmd_imm   = 16'($urandom);
      @(negedge clk);
      check("stall_valid", {31'b0, rsp_valid}, 32'd1);
      check("stall_data", {16'b0, rsp_data}, {16'b0, exp_d});
      check("stall_flags", {29'b0, rsp_flags}, {29'b0, exp_f});
      check("stall_ready", {31'b0, cmd_ready}, 32'd0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
`ifdef PERF_CNT_EN
    exp_stall += stall;
    exp_cmds++;
`endif
    @(negedge clk);                     // handshake edge passed: IDLE
    rsp_ready = 1'b0;
    check("back_to_idle_ready", {31'b0, cmd_ready}, 32'd1);
    check("back_to_idle_valid", {31'b0, rsp_valid}, 32'd0);
`ifdef PERF_CNT_EN
    check("perf_cmds", {16'b0, perf_cmds}, 32'(exp_cmds & 16'hFFFF));
    check("perf_stall", {16'b0, perf_stall}, 32'(exp_stall & 16'hFFFF));
`endif
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  dst;
    logic [2:0]  srca;
    logic [2:0]  srcb;
    logic [15:0] imm;
    logic [15:0] exp_d;
    logic [2:0]  exp_f;
  } vec_t;

  vec_t vecs [14];

  initial begin
    logic [15:0] md;
    logic [2:0]  mf;
    logic        minc;
    logic [2:0]  rop, rd, ra, rb;
    logic [15:0] rimm;

    total = 0;
    bad   = 0;
`ifdef PERF_CNT_EN
    exp_cmds  = 0;
    exp_stall = 0;
`endif

    // Directed vectors. Registers start at 0 and C starts at 0.
    vecs[0]  = '{3'd7, 3'd1, 3'd0, 3'd0, 16'h1234, 16'h1234, 3'b000}; // LOAD R1
    vecs[1]  = '{3'd7, 3'd2, 3'd0, 3'd0, 16'h00FF, 16'h00FF, 3'b000}; // LOAD R2
    vecs[2]  = '{3'd2, 3'd3, 3'd1, 3'd2, 16'h0000, 16'h1333, 3'b000}; // ADD R3
    vecs[3]  = '{3'd7, 3'd4, 3'd0, 3'd0, 16'hFFFF, 16'hFFFF, 3'b010}; // LOAD R4
    vecs[4]  = '{3'd2, 3'd5, 3'd4, 3'd2, 16'h0000, 16'h00FE, 3'b100}; // ADD carry out
    vecs[5]  = '{3'd2, 3'd6, 3'd1, 3'd2, 16'h0000, 16'h1334, 3'b000}; // ADD carry in
    vecs[6]  = '{3'd0, 3'd7, 3'd1, 3'd0, 16'h0000, 16'hEDCC, 3'b010}; // NEG
    vecs[7]  = '{3'd5, 3'd7, 3'd1, 3'd2, 16'h0000, 16'h12FF, 3'b000}; // OR
    vecs[8]  = '{3'd6, 3'd7, 3'd1, 3'd2, 16'h0000, 16'h34FF, 3'b000}; // PACK
    vecs[9]  = '{3'd7, 3'd2, 3'd0, 3'd0, 16'h0000, 16'h0000, 3'b001}; // LOAD R2=0
    vecs[10] = '{3'd4, 3'd7, 3'd1, 3'd2, 16'h0000, 16'h0000, 3'b001}; // AND -> Z
    vecs[11] = '{3'd1, 3'd1, 3'd1, 3'd0, 16'h0000, 16'h1235, 3'b000}; // INC R1 in place
    vecs[12] = '{3'd1, 3'd1, 3'd1, 3'd0, 16'h0000, 16'h1236, 3'b000}; // INC R1 again
    vecs[13] = '{3'd3, 3'd3, 3'd1, 3'd4, 16'h0000, 16'h1235, 3'b000}; // A+(B>>>1), B=-1

    // Reset block.
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    cmd_op    = '0;
    cmd_dst   = '0;
    cmd_srca  = '0;
    cmd_srcb  = '0;
    cmd_imm   = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rsp_data", {16'b0, rsp_data}, 32'd0);
    check("rst_rsp_flags", {29'b0, rsp_flags}, 32'd0);
    check("rst_alu_inA", {16'b0, alu_inA}, 32'd0);
    check("rst_alu_inB", {16'b0, alu_inB}, 32'd0);
    check("rst_alu_opc", {29'b0, alu_opc}, 32'd0);
    check("rst_alu_inC", {31'b0, alu_inC}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table. The model is stepped too so later phases stay in sync.
    for (int i = 0; i < 14; i++) begin
      model_step(vecs[i].op, int'(vecs[i].dst), int'(vecs[i].srca), int'(vecs[i].srcb),
                 vecs[i].imm, md, mf, minc);
      do_cmd(vecs[i].op, vecs[i].dst, vecs[i].srca, vecs[i].srcb, vecs[i].imm, 0,
             vecs[i].exp_d, vecs[i].exp_f, minc);
    end

    // Response held for 4 cycles. cmd_valid is pulsed during the hold and
    // must be ignored.
    model_step(3'd5, 0, 1, 3, 16'h0, md, mf, minc);
    do_cmd(3'd5, 3'd0, 3'd1, 3'd3, 16'h0, 4, md, mf, minc);

    // Reset during EXEC: the command is lost and never written back.
    cmd_valid = 1'b1;
    cmd_op    = 3'd7;
    cmd_dst   = 3'd5;
    cmd_imm   = 16'hABCD;
    @(negedge clk);                     // FETCH
    cmd_valid = 1'b0;
    @(negedge clk);                     // EXEC
    rst_n = 1'b0;
    #1;
    check("abort_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    check("abort_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
`ifdef PERF_CNT_EN
    exp_cmds  = 0;
    exp_stall = 0;
`endif
    @(negedge clk);
    model_step(3'd5, 6, 5, 5, 16'h0, md, mf, minc);
    do_cmd(3'd5, 3'd6, 3'd5, 3'd5, 16'h0, 0, md, mf, minc);
    check("abort_no_writeback", {16'b0, md}, 32'd0);

    // Randomized commands against the reference model.
    for (int n = 0; n < 60; n++) begin
      rop  = 3'($urandom_range(0, 7));
      rd   = 3'($urandom_range(0, 7));
      ra   = 3'($urandom_range(0, 7));
      rb   = 3'($urandom_range(0, 7));
      rimm = 16'($urandom);
      // Keep LOADs frequent so the register file carries varied values.
      if ($urandom_range(0, 3) == 0) rop = 3'd7;
      model_step(rop, int'(rd), int'(ra), int'(rb), rimm, md, mf, minc);
      do_cmd(rop, rd, ra, rb, rimm, $urandom_range(0, 2), md, mf, minc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety limit on total run time.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
